// File: rtl/msk_share_arbiter.sv
// -----------------------------------------------------------------------------
// msk_share_arbiter
//
// Round-robin controller sharing one downstream masked gadget between N
// requesters. The winning requester's sharing is routed through a chain of
// masked multiplexers (select driven only by control bits). It is latched into
// a share register and held stable for LAT cycles. The register is then
// scrubbed to zero for one cycle, so that sharings of different requesters
// never follow each other directly on the same wires.
//
// Parameters:
//   d      shares per masked bit (1..8)
//   count  masked bits per sharing
//   N      number of requesters (2..4)
//   LAT    hold cycles for the downstream gadget (1..15)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   req         [N]          per-requester request (control, never share data)
//   in_shares   [N*count*d]  requester i's sharing at [(i+1)*count*d-1 : i*count*d]
//   grant       [N]          registered one-hot grant, zero when idle
//   out_shares  [count*d]    registered sharing presented to the gadget
//   out_valid                high while out_shares holds a granted sharing
//   done        [N]          one-cycle pulse on the last hold cycle
// -----------------------------------------------------------------------------

// Masked 2:1 multiplexer. The select is a public control bit, so it is simply
// replicated across every share wire; no share bit influences another.
module msk_mux #(
    parameter int W = 2
) (
    input  logic         sel,
    input  logic [W-1:0] in_true,
    input  logic [W-1:0] in_false,
    output logic [W-1:0] out
);
    assign out = ({W{sel}} & in_true) | ({W{~sel}} & in_false);
endmodule

module msk_share_arbiter #(
    parameter int d     = 2,
    parameter int count = 1,
    parameter int N     = 2,
    parameter int LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*count*d-1:0] in_shares,
    output logic [N-1:0]         grant,
    output logic [count*d-1:0]   out_shares,
    output logic                 out_valid,
    output logic [N-1:0]         done
);
    localparam int SW    = count * d;
    localparam int PTR_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       counter;
    logic [PTR_W-1:0] pointer;

    logic [N-1:0]     next_grant;
    logic [PTR_W-1:0] next_idx;
    logic             found;
    int               idx;

    // Round-robin pick: first asserted req scanning upward from pointer+1.
    // NOTE: every signal assigned in this block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_grant = '0;
        next_idx   = '0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(pointer) + k) % N;
            if (!found && req[idx]) begin
                found           = 1'b1;
                next_grant[idx] = 1'b1;
                next_idx        = PTR_W'(idx);
            end
        end
    end

    // Mux chain: stage 0 starts from an all-zero sharing, and each stage
    // replaces the running value only if its one-hot select bit is set. With
    // next_grant zero the chain yields zero, and a non-selected sharing never
    // reaches the output.
    logic [SW-1:0] chain [N+1];
    assign chain[0] = '0;

    for (genvar i = 0; i < N; i++) begin : g_mux
        msk_mux #(.W(SW)) u_mux (
            .sel      (next_grant[i]),
            .in_true  (in_shares[i*SW +: SW]),
            .in_false (chain[i]),
            .out      (chain[i+1])
        );
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            out_shares <= '0;
            out_valid  <= 1'b0;
            done       <= '0;
            counter    <= '0;
            pointer    <= PTR_W'(N - 1);
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (|req) begin
                        out_shares <= chain[N];
                        grant      <= next_grant;
                        pointer    <= next_idx;
                        counter    <= 4'(LAT - 1);
                        out_valid  <= 1'b1;
                        // A single hold cycle is also the last one.
                        done       <= (LAT == 1) ? next_grant : '0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (counter == 4'd0) begin
                        grant      <= '0;
                        out_shares <= '0;
                        out_valid  <= 1'b0;
                        done       <= '0;
                        state      <= CLEAR;
                    end else begin
                        counter <= counter - 4'd1;
                        // done is registered, so it is set on the edge that
                        // enters the cycle where the counter reaches zero.
                        done    <= (counter == 4'd1) ? grant : '0;
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_msk_share_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for msk_share_arbiter. Three instances (N=2, d=2, count=1) with
// LAT=3, 2 and 1 receive the same stimulus. For every cycle a small
// transaction model pushes the expected outputs of the following cycles into a
// per-instance queue; each cycle the oldest entry is popped and compared.
// -----------------------------------------------------------------------------
module tb_msk_share_arbiter;
    localparam int NI = 3;

    typedef struct packed {
        logic [1:0] grant;
        logic       valid;
        logic [1:0] shares;
        logic [1:0] done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] in_shares;

    logic [1:0] grant_w  [NI];
    logic [1:0] shares_w [NI];
    logic       valid_w  [NI];
    logic [1:0] done_w   [NI];

    exp_t exp_q [NI][$];
    int   model_ptr [NI];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    msk_share_arbiter #(.d(2), .count(1), .N(2), .LAT(3)) u_dut_lat3 (
        .clk(clk), .rst(rst), .req(req), .in_shares(in_shares),
        .grant(grant_w[0]), .out_shares(shares_w[0]),
        .out_valid(valid_w[0]), .done(done_w[0])
    );

    msk_share_arbiter #(.d(2), .count(1), .N(2), .LAT(2)) u_dut_lat2 (
        .clk(clk), .rst(rst), .req(req), .in_shares(in_shares),
        .grant(grant_w[1]), .out_shares(shares_w[1]),
        .out_valid(valid_w[1]), .done(done_w[1])
    );

    msk_share_arbiter #(.d(2), .count(1), .N(2), .LAT(1)) u_dut_lat1 (
        .clk(clk), .rst(rst), .req(req), .in_shares(in_shares),
        .grant(grant_w[2]), .out_shares(shares_w[2]),
        .out_valid(valid_w[2]), .done(done_w[2])
    );

    function automatic int lat_of(input int i);
        return 3 - i;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Predict the outputs that follow the inputs just driven.
    task automatic model(input int i, input logic r, input logic [1:0] rq, input logic [3:0] sh);
        exp_t e;
        exp_t z;
        int   w;
        int   nxt;
        z = '0;
        if (r) begin
            exp_q[i].delete();
            model_ptr[i] = 1;
            exp_q[i].push_back(z);
        end else if (exp_q[i].size() == 0) begin
            // Model is idle this cycle: decide the next transaction.
            w   = -1;
            nxt = (model_ptr[i] == 0) ? 1 : 0;
            if (rq[nxt])
                w = nxt;
            else if (rq[model_ptr[i]])
                w = model_ptr[i];
            if (w < 0) begin
                exp_q[i].push_back(z);
            end else begin
                model_ptr[i] = w;
                for (int j = 0; j < lat_of(i); j++) begin
                    e.grant  = (w == 0) ? 2'b01 : 2'b10;
                    e.valid  = 1'b1;
                    e.shares = (w == 0) ? sh[1:0] : sh[3:2];
                    e.done   = (j == lat_of(i) - 1) ? e.grant : 2'b00;
                    exp_q[i].push_back(e);
                end
                exp_q[i].push_back(z);  // CLEAR cycle
                exp_q[i].push_back(z);  // following IDLE cycle
            end
        end
    endtask

    task automatic compare(input int i);
        exp_t e;
        if (exp_q[i].size() == 0) begin
            check($sformatf("sb_empty%0d", i), 32'd0, 32'd1);
        end else begin
            e = exp_q[i].pop_front();
            check($sformatf("grant_lat%0d", lat_of(i)),  32'(grant_w[i]),  32'(e.grant));
            check($sformatf("valid_lat%0d", lat_of(i)),  32'(valid_w[i]),  32'(e.valid));
            check($sformatf("shares_lat%0d", lat_of(i)), 32'(shares_w[i]), 32'(e.shares));
            check($sformatf("done_lat%0d", lat_of(i)),   32'(done_w[i]),   32'(e.done));
        end
    endtask

    // One cycle: compare current outputs, drive new inputs, update the model.
    task automatic step(input logic r, input logic [1:0] rq, input logic [3:0] sh);
        @(negedge clk);
        for (int i = 0; i < NI; i++) compare(i);
        rst       = r;
        req       = rq;
        in_shares = sh;
        for (int i = 0; i < NI; i++) model(i, r, rq, sh);
    endtask

    task automatic settle();
        for (int k = 0; k < 6; k++) step(1'b0, 2'b00, 4'($urandom));
    endtask

    initial begin
        // Reset with all requests high and random shares.
        rst       = 1'b1;
        req       = 2'b11;
        in_shares = 4'($urandom);
        for (int i = 0; i < NI; i++) model(i, 1'b1, req, in_shares);
        step(1'b1, 2'b11, 4'($urandom));
        // Release with both requesting: requester 0 must win first.
        step(1'b0, 2'b11, 4'b1001);
        settle();

        // Single request from requester 0 with sharing 2'b10.
        step(1'b0, 2'b01, 4'b0110);
        settle();

        // Round robin under constant contention.
        for (int k = 0; k < 16; k++) step(1'b0, 2'b11, 4'($urandom));
        settle();

        // Lone request from requester 1.
        step(1'b0, 2'b10, 4'b1100);
        settle();

        // Reset in the second hold cycle of the LAT=3 instance, then contention.
        step(1'b0, 2'b10, 4'b0111);
        step(1'b0, 2'b00, 4'($urandom));
        step(1'b1, 2'b00, 4'($urandom));
        for (int k = 0; k < 6; k++) step(1'b0, 2'b11, 4'($urandom));
        settle();

        // Share isolation: all inputs toggle every cycle during the hold.
        step(1'b0, 2'b01, 4'b1010);
        for (int k = 0; k < 5; k++) step(1'b0, 2'b00, (k % 2 == 0) ? 4'b0101 : 4'b1010);
        settle();

        // Random traffic with occasional resets.
        for (int k = 0; k < 40; k++)
            step(($urandom_range(0, 15) == 0), 2'($urandom), 4'($urandom));
        settle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
